// File: rtl/mips_tb_pkg.sv
// Shared state encoding and fail codes for the CPU test controller.
package mips_tb_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD  = 3'd0,
        WAIT_ACTIVE = 3'd1,
        RUN         = 3'd2,
        CHECK       = 3'd3,
        DONE        = 3'd4
    } state_t;

    localparam logic [2:0] FAIL_NONE     = 3'd0;
    localparam logic [2:0] FAIL_NO_START = 3'd1;
    localparam logic [2:0] FAIL_TIMEOUT  = 3'd2;
    localparam logic [2:0] FAIL_V0       = 3'd3;
    localparam logic [2:0] FAIL_MISALIGN = 3'd4;

endpackage

// File: rtl/clk_enable_stall_gen.sv
// Periodic clock-enable stall generator: a wrap counter 0..STALL_PERIOD-1
// whose last value stalls the CPU for one cycle. STALL_PERIOD=0 disables it.
module clk_enable_stall_gen #(
    parameter int STALL_PERIOD = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic advance,
    input  logic restart,
    output logic enable_out
);

    localparam int            CW   = (STALL_PERIOD < 2) ? 1 : $clog2(STALL_PERIOD);
    localparam logic [CW-1:0] LAST = CW'((STALL_PERIOD < 2) ? 0 : STALL_PERIOD - 1);

    generate
        if (STALL_PERIOD == 1 || STALL_PERIOD < 0) begin : g_bad_period
            $error("clk_enable_stall_gen: STALL_PERIOD must be 0 or at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;

    // Next counter value; restart takes priority over advance.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Wrap counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Enable for the cycle following this edge, so the parent can register it
    // alongside its own next state without adding a cycle of lag.
    assign enable_out = (STALL_PERIOD < 2) ? 1'b1 : (cnt_d != LAST);

endmodule

// File: rtl/mips_cpu_test_controller.sv
// Sequencing and checking controller for CPU test benches: holds the CPU in
// reset, waits for it to start, watches for finish/timeout/misalignment,
// checks v0 and reports a sticky verdict. All outputs are flops.
module mips_cpu_test_controller
    import mips_tb_pkg::*;
#(
    parameter int RESET_CYCLES   = 2,
    parameter int START_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int STALL_PERIOD   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] instr_address,
    input  logic [31:0] register_v0,
    input  logic [31:0] expected_v0,
    input  logic        check_v0_en,
    output logic        cpu_reset,
    output logic        cpu_clk_enable,
    output logic        done,
    output logic        pass,
    output logic [2:0]  fail_code,
    output logic [31:0] cycle_count,
    output logic [31:0] final_v0
);

    generate
        if (RESET_CYCLES < 1 || START_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
            $error("mips_cpu_test_controller: cycle parameters must be at least 1");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        cpu_clk_enable_q, cpu_clk_enable_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [2:0]  fail_code_q, fail_code_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] final_v0_q, final_v0_d;

    logic        stall_advance, stall_restart, stall_enable;

    // Only the word-alignment bits of the address matter here.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^instr_address[31:2];

    // Next-state and next-output logic for the test sequence.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cpu_reset_d   = 1'b0;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_code_d   = fail_code_q;
        cycle_count_d = cycle_count_q;
        final_v0_d    = final_v0_q;

        case (state_q)
            RESET_HOLD: begin
                cpu_reset_d = 1'b1;
                if (timer_q == 32'(RESET_CYCLES - 1)) begin
                    state_d     = WAIT_ACTIVE;
                    timer_d     = '0;
                    cpu_reset_d = 1'b0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            WAIT_ACTIVE: begin
                if (cpu_active) begin
                    state_d = RUN;
                end else if (timer_q == 32'(START_CYCLES - 1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_code_d = FAIL_NO_START;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            RUN: begin
                // Finish beats misalignment beats timeout in the same cycle.
                if (!cpu_active) begin
                    state_d    = CHECK;
                    final_v0_d = register_v0;
                end else if (instr_address[1:0] != 2'b00) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_code_d = FAIL_MISALIGN;
                end else if (cycle_count_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_code_d = FAIL_TIMEOUT;
                end else if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
            end
            CHECK: begin
                state_d = DONE;
                done_d  = 1'b1;
                if (check_v0_en && (final_v0_q != expected_v0)) begin
                    pass_d      = 1'b0;
                    fail_code_d = FAIL_V0;
                end else begin
                    pass_d      = 1'b1;
                    fail_code_d = FAIL_NONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RESET_HOLD;
            end
        endcase
    end

    // Stall counter restarts on WAIT_ACTIVE entry and runs in WAIT_ACTIVE/RUN.
    assign stall_restart = (state_q == RESET_HOLD) && (state_d == WAIT_ACTIVE);
    assign stall_advance = (state_q == WAIT_ACTIVE) || (state_q == RUN);

    clk_enable_stall_gen #(
        .STALL_PERIOD (STALL_PERIOD)
    ) u_stall_gen (
        .clk        (clk),
        .reset      (reset),
        .advance    (stall_advance),
        .restart    (stall_restart),
        .enable_out (stall_enable)
    );

    // Clock enable for the next cycle: frozen in DONE, stalled only while the
    // CPU is starting or running.
    always_comb begin
        case (state_d)
            DONE:             cpu_clk_enable_d = 1'b0;
            WAIT_ACTIVE, RUN: cpu_clk_enable_d = stall_enable;
            default:          cpu_clk_enable_d = 1'b1;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RESET_HOLD;
            timer_q          <= '0;
            cpu_reset_q      <= 1'b1;
            cpu_clk_enable_q <= 1'b1;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            fail_code_q      <= FAIL_NONE;
            cycle_count_q    <= '0;
            final_v0_q       <= '0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            cpu_reset_q      <= cpu_reset_d;
            cpu_clk_enable_q <= cpu_clk_enable_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            fail_code_q      <= fail_code_d;
            cycle_count_q    <= cycle_count_d;
            final_v0_q       <= final_v0_d;
        end
    end

    assign cpu_reset      = cpu_reset_q;
    assign cpu_clk_enable = cpu_clk_enable_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_code      = fail_code_q;
    assign cycle_count    = cycle_count_q;
    assign final_v0       = final_v0_q;

endmodule

// File: tb/tb_mips_cpu_test_controller.sv
// Bench for mips_cpu_test_controller: a small CPU model drives both a
// no-stall and a STALL_PERIOD=3 instance; expected verdicts are queued when a
// run is set up and compared when the controllers report done.
module tb_mips_cpu_test_controller;
    import mips_tb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        cpu_active;
    logic [31:0] instr_address;
    logic [31:0] register_v0 = 32'h0;
    logic [31:0] expected_v0 = 32'h0;
    logic        check_v0_en = 1'b0;

    logic        dut_cpu_reset, dut_cpu_clk_enable, dut_done, dut_pass;
    logic [2:0]  dut_fail_code;
    logic [31:0] dut_cycle_count, dut_final_v0;
    logic        stl_cpu_reset, stl_cpu_clk_enable, stl_done, stl_pass;
    logic [2:0]  stl_fail_code;
    logic [31:0] stl_cycle_count, stl_final_v0;

    mips_cpu_test_controller #(
        .RESET_CYCLES(2), .START_CYCLES(4), .TIMEOUT_CYCLES(50), .STALL_PERIOD(0)
    ) u_dut (
        .clk(clk), .reset(reset), .cpu_active(cpu_active), .instr_address(instr_address),
        .register_v0(register_v0), .expected_v0(expected_v0), .check_v0_en(check_v0_en),
        .cpu_reset(dut_cpu_reset), .cpu_clk_enable(dut_cpu_clk_enable), .done(dut_done),
        .pass(dut_pass), .fail_code(dut_fail_code), .cycle_count(dut_cycle_count),
        .final_v0(dut_final_v0)
    );

    mips_cpu_test_controller #(
        .RESET_CYCLES(2), .START_CYCLES(4), .TIMEOUT_CYCLES(50), .STALL_PERIOD(3)
    ) u_stall (
        .clk(clk), .reset(reset), .cpu_active(cpu_active), .instr_address(instr_address),
        .register_v0(register_v0), .expected_v0(expected_v0), .check_v0_en(check_v0_en),
        .cpu_reset(stl_cpu_reset), .cpu_clk_enable(stl_cpu_clk_enable), .done(stl_done),
        .pass(stl_pass), .fail_code(stl_fail_code), .cycle_count(stl_cycle_count),
        .final_v0(stl_final_v0)
    );

    typedef struct packed {
        logic        done;
        logic        pass;
        logic [2:0]  fc;
        logic [31:0] cc;
        logic [31:0] v0;
        logic [15:0] lat;   // negedges from cpu_reset release to done
    } res_t;

    typedef struct {
        string name;
        res_t  r;
        bit    via_check;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // CPU model: k counts cycles since cpu_reset was released. Active rises
    // one cycle after release and stays up for mdl_len RUN samples (or forever).
    bit mdl_rise = 1'b0;
    bit mdl_hold = 1'b0;
    int mdl_len  = 0;
    int mdl_badk = 0;
    int k        = 0;

    always @(negedge clk) begin
        if (reset || dut_cpu_reset) begin
            k             = 0;
            cpu_active    = 1'b0;
            instr_address = 32'h0;
        end else begin
            k             = k + 1;
            cpu_active    = mdl_rise && (k >= 2) && (mdl_hold || (k <= 2 + mdl_len));
            instr_address = (mdl_badk != 0 && k == mdl_badk) ? 32'h0000_0006
                                                              : 32'h0000_0100 + 32'(4 * k);
        end
    end

    function automatic string fmt(res_t r);
        return $sformatf("done=%0b pass=%0b code=%0d cycles=%0d v0=%h lat=%0d",
                         r.done, r.pass, r.fc, r.cc, r.v0, r.lat);
    endfunction

    task automatic setup(input bit rise, input bit hold, input int len, input int badk,
                         input logic [31:0] v0, input logic [31:0] exp_v0, input bit chk);
        mdl_rise    = rise;
        mdl_hold    = hold;
        mdl_len     = len;
        mdl_badk    = badk;
        register_v0 = v0;
        expected_v0 = exp_v0;
        check_v0_en = chk;
    endtask

    // Reset both controllers, run to done (bounded) and collect observations.
    task automatic do_run(input bit via_check, output res_t rd, output res_t rs,
                          output int rst_hi, output int en_bad);
        int           lat_d;
        int           lat_s;
        logic [511:0] stl_en;
        lat_d = -1; lat_s = -1; rst_hi = 0; en_bad = 0; stl_en = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (dut_cpu_reset !== 1'b1) break;
            if (stl_cpu_reset !== dut_cpu_reset) en_bad++;
            rst_hi++;
            @(negedge clk);
        end
        for (int j = 0; j < 400; j++) begin
            if (lat_d < 0 && dut_done === 1'b1) lat_d = j;
            if (lat_s < 0 && stl_done === 1'b1) lat_s = j;
            if (lat_d >= 0 && lat_s >= 0) break;
            if (lat_d < 0 && dut_cpu_clk_enable !== 1'b1) en_bad++;
            if (lat_s < 0) stl_en[j] = stl_cpu_clk_enable;
            @(negedge clk);
        end
        // Stall pattern 1,1,0 from WAIT_ACTIVE entry; the CHECK cycle is never stalled.
        for (int j = 0; j < lat_s; j++) begin
            if (stl_en[j] !== ((via_check && j == lat_s - 1) ? 1'b1 : ((j % 3) != 2))) en_bad++;
        end
        repeat (3) @(negedge clk);
        if (dut_cpu_clk_enable !== 1'b0 || stl_cpu_clk_enable !== 1'b0 ||
            dut_cpu_reset !== 1'b0 || stl_cpu_reset !== 1'b0) en_bad++;
        rd = {dut_done, dut_pass, dut_fail_code, dut_cycle_count, dut_final_v0, 16'(lat_d)};
        rs = {stl_done, stl_pass, stl_fail_code, stl_cycle_count, stl_final_v0, 16'(lat_s)};
    endtask

    task automatic test_reset();
        logic [70:0] obs_d, obs_s;
        logic [70:0] want;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        want  = {1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1};
        obs_d = {dut_done, dut_pass, dut_fail_code, dut_cycle_count, dut_final_v0,
                 dut_cpu_reset, dut_cpu_clk_enable};
        obs_s = {stl_done, stl_pass, stl_fail_code, stl_cycle_count, stl_final_v0,
                 stl_cpu_reset, stl_cpu_clk_enable};
        tests++;
        if (obs_d !== want) begin fails++; $display("FAIL reset state: got %h, want %h", obs_d, want); end
        tests++;
        if (obs_s !== want) begin fails++; $display("FAIL stall reset state: got %h, want %h", obs_s, want); end
    endtask

    task automatic test_basic_pass();
        res_t rd, rs; int rh, eb; exp_t e;
        setup(1'b1, 1'b0, 20, 0, 32'h5, 32'h5, 1'b1);
        sb.push_back('{"basic", {1'b1, 1'b1, FAIL_NONE, 32'd20, 32'h5, 16'd24}, 1'b1});
        do_run(1'b1, rd, rs, rh, eb);
        e = sb.pop_front();
        tests++;
        if (rd !== e.r) begin fails++; $display("FAIL %s verdict: got %s, want %s", e.name, fmt(rd), fmt(e.r)); end
        tests++;
        if (rs !== e.r) begin fails++; $display("FAIL %s stall verdict: got %s, want %s", e.name, fmt(rs), fmt(e.r)); end
        tests++;
        if (rh !== 2) begin fails++; $display("FAIL %s cpu_reset cycles: got %0d, want 2", e.name, rh); end
        tests++;
        if (eb !== 0) begin fails++; $display("FAIL %s enable/reset pattern: got %0d bad samples, want 0", e.name, eb); end
    endtask

    task automatic test_v0_check();
        res_t rd, rs; int rh, eb; exp_t e;
        for (int c = 0; c < 2; c++) begin
            setup(1'b1, 1'b0, 20, 0, 32'h5, 32'h6, (c == 0));
            if (c == 0) sb.push_back('{"v0_mismatch", {1'b1, 1'b0, FAIL_V0, 32'd20, 32'h5, 16'd24}, 1'b1});
            else        sb.push_back('{"v0_unchecked", {1'b1, 1'b1, FAIL_NONE, 32'd20, 32'h5, 16'd24}, 1'b1});
            do_run(1'b1, rd, rs, rh, eb);
            e = sb.pop_front();
            tests++;
            if (rd !== e.r) begin fails++; $display("FAIL %s verdict: got %s, want %s", e.name, fmt(rd), fmt(e.r)); end
            tests++;
            if (rs !== e.r) begin fails++; $display("FAIL %s stall verdict: got %s, want %s", e.name, fmt(rs), fmt(e.r)); end
            tests++;
            if (eb !== 0) begin fails++; $display("FAIL %s enable/reset pattern: got %0d bad samples, want 0", e.name, eb); end
        end
    endtask

    task automatic test_timeout();
        res_t rd, rs; int rh, eb; exp_t e;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                setup(1'b1, 1'b1, 0, 0, 32'h5, 32'h5, 1'b1);
                sb.push_back('{"timeout", {1'b1, 1'b0, FAIL_TIMEOUT, 32'd49, 32'h0, 16'd52}, 1'b0});
            end else begin
                setup(1'b1, 1'b0, 49, 0, 32'h5, 32'h5, 1'b1);
                sb.push_back('{"finish_at_limit", {1'b1, 1'b1, FAIL_NONE, 32'd49, 32'h5, 16'd53}, 1'b1});
            end
            do_run(sb[0].via_check, rd, rs, rh, eb);
            e = sb.pop_front();
            tests++;
            if (rd !== e.r) begin fails++; $display("FAIL %s verdict: got %s, want %s", e.name, fmt(rd), fmt(e.r)); end
            tests++;
            if (rs !== e.r) begin fails++; $display("FAIL %s stall verdict: got %s, want %s", e.name, fmt(rs), fmt(e.r)); end
            tests++;
            if (eb !== 0) begin fails++; $display("FAIL %s enable/reset pattern: got %0d bad samples, want 0", e.name, eb); end
        end
    endtask

    task automatic test_no_start();
        res_t rd, rs; int rh, eb; exp_t e;
        setup(1'b0, 1'b0, 0, 0, 32'h5, 32'h5, 1'b1);
        sb.push_back('{"no_start", {1'b1, 1'b0, FAIL_NO_START, 32'd0, 32'h0, 16'd4}, 1'b0});
        do_run(1'b0, rd, rs, rh, eb);
        e = sb.pop_front();
        tests++;
        if (rd !== e.r) begin fails++; $display("FAIL %s verdict: got %s, want %s", e.name, fmt(rd), fmt(e.r)); end
        tests++;
        if (rs !== e.r) begin fails++; $display("FAIL %s stall verdict: got %s, want %s", e.name, fmt(rs), fmt(e.r)); end
        tests++;
        if (eb !== 0) begin fails++; $display("FAIL %s enable/reset pattern: got %0d bad samples, want 0", e.name, eb); end
    endtask

    task automatic test_misalign_then_reset();
        res_t rd, rs; int rh, eb; exp_t e;
        logic [38:0] obs;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                setup(1'b1, 1'b0, 20, 10, 32'h9, 32'h9, 1'b1);
                sb.push_back('{"misalign", {1'b1, 1'b0, FAIL_MISALIGN, 32'd7, 32'h0, 16'd10}, 1'b0});
            end else begin
                setup(1'b1, 1'b0, 20, 0, 32'h9, 32'h9, 1'b1);
                sb.push_back('{"rerun_after_reset", {1'b1, 1'b1, FAIL_NONE, 32'd20, 32'h9, 16'd24}, 1'b1});
            end
            do_run(sb[0].via_check, rd, rs, rh, eb);
            e = sb.pop_front();
            tests++;
            if (rd !== e.r) begin fails++; $display("FAIL %s verdict: got %s, want %s", e.name, fmt(rd), fmt(e.r)); end
            tests++;
            if (rs !== e.r) begin fails++; $display("FAIL %s stall verdict: got %s, want %s", e.name, fmt(rs), fmt(e.r)); end
            tests++;
            if (eb !== 0) begin fails++; $display("FAIL %s enable/reset pattern: got %0d bad samples, want 0", e.name, eb); end
            if (c == 0) begin
                // Reset from DONE must clear the verdict on the very next edge.
                reset = 1'b1;
                @(negedge clk);
                obs = {dut_done, dut_pass, dut_fail_code, dut_cycle_count, dut_cpu_reset, dut_cpu_clk_enable};
                tests++;
                if (obs !== {1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b1}) begin
                    fails++; $display("FAIL reset_in_done: got %h, want %h", obs, {1'b0, 1'b0, 3'd0, 32'd0, 1'b1, 1'b1});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_v0_check();
        test_timeout();
        test_no_start();
        test_misalign_then_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_cpu_test_controller.md
Name: mips_cpu_test_controller

Overview:
- Reusable sequencing and checking block for CPU test benches. Replaces open-coded reset, timeout and finish logic with one parametrised FSM.
- Drives reset and clk_enable into a CPU under test and watches its active flag and instruction address.
- Checks register_v0 against an expected value when the run finishes.
- Adds a periodic clock-enable stall mode and sticky pass/fail reporting with fail codes.

Parameters:
- RESET_CYCLES, 2: cycles cpu_reset is held high; must be at least 1.
- START_CYCLES, 4: maximum cycles after reset release for cpu_active to rise.
- TIMEOUT_CYCLES, 10000: maximum RUN cycles before a timeout is declared.
- STALL_PERIOD, 0: 0 means clk_enable is always 1. N ≥ 2 means clk_enable is low for 1 cycle in every N (WAIT_ACTIVE and RUN only).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; restarts the whole sequence.
- cpu_active  in  1  CPU running flag.
- instr_address  in  32  CPU instruction address.
- register_v0  in  32  CPU v0 debug output.
- expected_v0  in  32  value v0 must equal at finish.
- check_v0_en  in  1  1 = compare v0 at finish; sampled in CHECK.
- cpu_reset  out  1  reset to the CPU.
- cpu_clk_enable  out  1  clock enable to the CPU.
- done  out  1  sticky; high once a verdict exists.
- pass  out  1  valid when done=1.
- fail_code  out  3  0 none, 1 NO_START, 2 TIMEOUT, 3 V0_MISMATCH, 4 MISALIGNED.
- cycle_count  out  32  RUN cycles elapsed; saturating.
- final_v0  out  32  register_v0 captured on entry to CHECK.

Behaviour:
- Reset (clk edge with reset=1) forces:
  - state RESET_HOLD, hold counter 0;
  - cpu_reset=1, cpu_clk_enable=1;
  - done=0, pass=0, fail_code=0, cycle_count=0, final_v0=0;
  - stall counter 0.
- Reset asserted in any state, including DONE, restarts the sequence.
- RESET_HOLD:
  - cpu_reset=1;
  - after RESET_CYCLES cycles with reset low, go to WAIT_ACTIVE, and cpu_reset=0 from that edge onward.
- WAIT_ACTIVE:
  - cpu_active=1 → RUN;
  - otherwise, after START_CYCLES cycles → DONE with fail_code=1.
- RUN, evaluated per cycle in this priority order:
  1. cpu_active=0 → CHECK (finish always beats timeout in the same cycle).
  2. instr_address[1:0]≠0 → DONE with fail_code=4.
  3. cycle_count==TIMEOUT_CYCLES-1 → DONE with fail_code=2.
  4. Otherwise cycle_count increments.
  - cycle_count counts every RUN cycle, stalled cycles included, and saturates at 32'hFFFFFFFF.
- CHECK (1 cycle):
  - final_v0 was captured on the entry edge.
  - If check_v0_en=1 and final_v0≠expected_v0 → fail_code=3, pass=0; otherwise pass=1.
  - Next state is DONE.
- DONE:
  - done=1, and done, pass, fail_code, cycle_count and final_v0 all hold until reset;
  - cpu_clk_enable=0, which freezes the CPU;
  - cpu_reset=0.
- Verdict latency: done rises 2 edges after the first cycle in which cpu_active=0 is seen in RUN (RUN→CHECK→DONE).
- Stall mode, when STALL_PERIOD ≥ 2:
  - stall counter runs 0..STALL_PERIOD-1 and wraps to 0;
  - counter advances only in WAIT_ACTIVE and RUN, and resets to 0 on entry to WAIT_ACTIVE;
  - cpu_clk_enable=0 exactly when counter==STALL_PERIOD-1.
- STALL_PERIOD=1 is illegal and is caught by an elaboration-time assertion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package mips_tb_pkg holds:
  - state enum {RESET_HOLD, WAIT_ACTIVE, RUN, CHECK, DONE}, 3 bits;
  - fail code localparams FAIL_NONE=0, FAIL_NO_START=1, FAIL_TIMEOUT=2, FAIL_V0=3, FAIL_MISALIGN=4.
- One sub-module, clk_enable_stall_gen:
  - parameter STALL_PERIOD;
  - ports clk, reset, advance, restart, enable_out.
  - It owns the wrap counter.

Test Plan:
1. Defaults; CPU model raises active 1 cycle after reset release, drops it after 20 cycles with v0=32'h0000_0005, expected_v0=5, check_v0_en=1 → cpu_reset high exactly 2 cycles; done=1, pass=1, fail_code=0, cycle_count=20, final_v0=5.
2. Same run but expected_v0=6 → pass=0, fail_code=3. With check_v0_en=0 → pass=1.
3. TIMEOUT_CYCLES=50; active never falls → done=1 on the RUN cycle where cycle_count reaches 49, fail_code=2, cpu_clk_enable=0 thereafter. Active falling exactly on that cycle instead → pass path taken, fail_code=0.
4. Active never rises, START_CYCLES=4 → fail_code=1 after 4 WAIT_ACTIVE cycles; cycle_count=0.
5. STALL_PERIOD=3 → cpu_clk_enable pattern 1,1,0 repeating from WAIT_ACTIVE entry. In a 20-cycle run, low on cycles 3,6,9,…; cycle_count still 20.
6. instr_address=32'h0000_0006 while active in RUN → fail_code=4. Reset asserted in DONE → done=0, cpu_reset=1 next cycle, sequence repeats and produces pass.
